mf_coef_mac: RTL

Tap-serial matched-filter engine. It is the reader side of the real-coefficient ROM.
- For each accepted input sample it shifts a delay line, then walks the coefficient ROM from address 0 to ORDER through rom_en/rom_addr.
- It multiplies each returned coefficient by the matching delay-line sample, accumulates, and emits one filter output per sample.
- It sits between the sample source and the detection/threshold stage; one instance serves the real path.

---
 rtl/mf_pkg.sv | 16 +
 rtl/mf_delay_line.sv | 24 ++
 rtl/mf_coef_mac.sv | 111 +++++++++++
 3 files changed

// File: rtl/mf_pkg.sv
// Shared defaults and types for the tap-serial matched-filter engine.
package mf_pkg;

   localparam int MF_ORDER  = 60;
   localparam int MF_DATA_W = 16;
   localparam int MF_ADDR_W = 32;
   localparam int MF_ACC_W  = 40;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

   // Smallest accumulator that cannot overflow over order+1 full-scale products.
   function automatic int acc_w_min(input int data_w, input int order);
      return 2 * data_w + $clog2(order + 1);
   endfunction

endpackage

// File: rtl/mf_delay_line.sv
// Sample delay line x[0..DEPTH-1]: x[0] takes the new sample on shift, with one indexed read port.
module mf_delay_line #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 61,
   parameter int SEL_W  = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     shift_en,
   input  logic signed [DATA_W-1:0] din,
   input  logic        [SEL_W-1:0]  sel,
   output logic signed [DATA_W-1:0] dout
);

   logic [DEPTH-1:0][DATA_W-1:0] x_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          x_q <= '0;
      else if (shift_en) x_q <= {x_q[DEPTH-2:0], din};
   end

   assign dout = x_q[sel];

endmodule

// File: rtl/mf_coef_mac.sv
// Tap-serial matched filter: walks the coefficient ROM 0..ORDER per sample and accumulates.
// Define MF_COEF_MAC_OVERRUN_EN to add a sticky overrun flag for samples dropped while busy.
module mf_coef_mac
   import mf_pkg::*;
#(
   parameter int ORDER  = MF_ORDER,
   parameter int DATA_W = MF_DATA_W,
   parameter int ADDR_W = MF_ADDR_W,
   parameter int ACC_W  = MF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_valid,
   output logic                     ready,
   output logic                     rom_en,
   output logic        [ADDR_W-1:0] rom_addr,
   input  logic signed [DATA_W-1:0] rom_data,
   output logic signed [ACC_W-1:0]  y,
   output logic                     y_valid
`ifdef MF_COEF_MAC_OVERRUN_EN
   ,
   output logic                     overrun
`endif
);

   localparam int               CNT_W = $clog2(ORDER + 1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ORDER);

   if (ACC_W < acc_w_min(DATA_W, ORDER)) begin : g_acc_chk
      $error("mf_coef_mac: ACC_W too narrow for ORDER/DATA_W");
   end

   state_e                    state_q;
   logic        [CNT_W-1:0]   cnt_q;
   logic        [CNT_W-1:0]   sel;
   logic signed [ACC_W-1:0]   acc_q;
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [ACC_W-1:0]   y_q;
   logic                      y_valid_q;
   logic signed [DATA_W-1:0]  x_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic                      accept;

   assign ready    = (state_q == IDLE);
   assign accept   = ready && sample_valid;
   assign rom_en   = (state_q == FETCH);
   assign rom_addr = rom_en ? ADDR_W'(cnt_q) : '0;
   assign y        = y_q;
   assign y_valid  = y_valid_q;

   // rom_data lags the address by one cycle, so pair it with the previous tap.
   assign sel   = (state_q == DRAIN) ? LAST : ((cnt_q == '0) ? '0 : cnt_q - 1'b1);
   assign prod  = rom_data * x_sel;
   assign acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

   mf_delay_line #(
      .DATA_W (DATA_W),
      .DEPTH  (ORDER + 1),
      .SEL_W  (CNT_W)
   ) u_dl (
      .clk      (clk),
      .rst      (rst),
      .shift_en (accept),
      .din      (sample_in),
      .sel      (sel),
      .dout     (x_sel)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         y_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (sample_valid) begin
               acc_q   <= '0;
               cnt_q   <= '0;
               state_q <= FETCH;
            end
            FETCH: begin
               if (cnt_q != '0) acc_q <= acc_d;
               if (cnt_q == LAST) state_q <= DRAIN;
               else               cnt_q   <= cnt_q + 1'b1;
            end
            DRAIN: begin
               y_q       <= acc_d;
               y_valid_q <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef MF_COEF_MAC_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       overrun_q <= 1'b0;
      else if (sample_valid && !ready) overrun_q <= 1'b1;
   end

   assign overrun = overrun_q;
`endif

endmodule
